soft_trig_scheduler: RTL

- Arbitrates three soft-trigger sources (software burst, periodic timer, PPS-aligned offset) onto one single-cycle trigger pulse with enforced minimum spacing.
- Sits in the control clock domain ahead of the trigger-domain flag synchroniser; trig_o feeds that synchroniser directly.
- Reports source, busy, completion and dropped requests for the register interface.

---
 rtl/soft_trig_scheduler.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/soft_trig_scheduler.sv
// soft_trig_scheduler
//   Arbitrates three soft-trigger sources (software burst, periodic timer,
//   PPS-aligned offset) onto one registered single-cycle trigger pulse, with a
//   minimum spacing between pulses set by holdoff_i.
//
// Ports
//   clk_i, rst_i        control clock, synchronous active-high reset
//   slow_ce_i           tick enable; delay/period/offset counts are in ticks
//   sw_ctrl_i[7:0]      [7:4] inter-pulse delay D, [3:1] burst length N-1, [0] go
//   per_en_i            periodic source enable
//   per_period_i        period P in ticks (0 disables)
//   pps_en_i, pps_i     PPS enable and single-cycle PPS flag
//   pps_offset_i        delay after PPS, in ticks
//   holdoff_i           minimum clk cycles between trig_o pulses
//   trig_o              single-cycle trigger pulse
//   trig_src_o          source of last pulse: 01 sw, 10 periodic, 11 PPS
//   busy_o              software burst in progress
//   sw_done_o           one-cycle pulse at burst completion
//   dropped_o           one-cycle pulse when a request is discarded
module soft_trig_scheduler #(
    parameter int HOLD_W = 8,
    parameter int TICK_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              slow_ce_i,
    input  logic [7:0]        sw_ctrl_i,
    input  logic              per_en_i,
    input  logic [TICK_W-1:0] per_period_i,
    input  logic              pps_en_i,
    input  logic              pps_i,
    input  logic [TICK_W-1:0] pps_offset_i,
    input  logic [HOLD_W-1:0] holdoff_i,
    output logic              trig_o,
    output logic [1:0]        trig_src_o,
    output logic              busy_o,
    output logic              sw_done_o,
    output logic              dropped_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FIRE = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              go_q;
    logic              sw_pend_q, sw_pend_d;
    logic              per_pend_q, per_pend_d;
    logic              pps_pend_q, pps_pend_d;
    logic [3:0]        d_q, d_d;
    logic [3:0]        n_q, n_d;
    logic [3:0]        dly_q, dly_d;
    logic [TICK_W-1:0] per_cnt_q, per_cnt_d;
    logic [TICK_W-1:0] pps_cnt_q, pps_cnt_d;
    logic              pps_run_q, pps_run_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              trig_q, trig_d;
    logic [1:0]        src_q, src_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;

    logic sw_edge, sw_accept, sw_drop;
    logic per_run, per_hit, per_drop;
    logic pps_set, pps_drop;
    logic g_pps, g_sw, g_per;
    logic hold_free;

    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        n_d       = n_q;
        dly_d     = dly_q;
        per_cnt_d = per_cnt_q;
        pps_cnt_d = pps_cnt_q;
        pps_run_d = pps_run_q;
        trig_d    = 1'b0;
        src_d     = src_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pps_set   = 1'b0;
        pps_drop  = 1'b0;
        g_pps     = 1'b0;
        g_sw      = 1'b0;
        g_per     = 1'b0;
        hold_free = (hold_q == '0);

        // Software go: rising edge only; any edge while a request is queued
        // or a burst is running is discarded.
        sw_edge   = sw_ctrl_i[0] & ~go_q;
        sw_drop   = sw_edge & (sw_pend_q | (state_q != S_IDLE));
        sw_accept = sw_edge & ~sw_drop;
        if (sw_accept) begin
            d_d = sw_ctrl_i[7:4];
            n_d = {1'b0, sw_ctrl_i[3:1]} + 4'd1;
        end

        // Periodic: >= rather than == so a period shrunk below the running
        // count still wraps instead of running away to the counter limit.
        per_run = per_en_i && (per_period_i != '0);
        per_hit = per_run && slow_ce_i && (per_cnt_q >= per_period_i - TICK_W'(1));
        if (!per_run)
            per_cnt_d = '0;
        else if (slow_ce_i)
            per_cnt_d = per_hit ? '0 : per_cnt_q + TICK_W'(1);
        per_drop = per_hit & per_pend_q;

        // PPS offset: the counter runs only for non-zero offsets and expires
        // on the tick that takes it from 1 to 0.
        if (pps_run_q && slow_ce_i) begin
            if (pps_cnt_q == TICK_W'(1)) begin
                pps_cnt_d = '0;
                pps_run_d = 1'b0;
                pps_set   = 1'b1;
            end else begin
                pps_cnt_d = pps_cnt_q - TICK_W'(1);
            end
        end
        if (pps_en_i && pps_i) begin
            if (pps_pend_q) begin
                pps_drop = 1'b1;
            end else begin
                pps_drop = pps_run_q;
                if (pps_offset_i == '0) begin
                    pps_cnt_d = '0;
                    pps_run_d = 1'b0;
                    pps_set   = 1'b1;
                end else begin
                    pps_cnt_d = pps_offset_i;
                    pps_run_d = 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (hold_free) begin
                    if (pps_pend_q) begin
                        g_pps  = 1'b1;
                        trig_d = 1'b1;
                        src_d  = 2'b11;
                    end else if (sw_pend_q) begin
                        g_sw    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_FIRE;
                    end else if (per_pend_q) begin
                        g_per  = 1'b1;
                        trig_d = 1'b1;
                        src_d  = 2'b10;
                    end
                end
            end
            S_FIRE: begin
                trig_d = 1'b1;
                src_d  = 2'b01;
                n_d    = n_q - 4'd1;
                if (n_q == 4'd1) begin
                    state_d = S_DONE;
                end else begin
                    dly_d   = d_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dly_q != 4'd0) begin
                    if (slow_ce_i)
                        dly_d = dly_q - 4'd1;
                end else if (hold_free) begin
                    state_d = S_FIRE;
                end
            end
            default: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Load holdoff on the same edge that raises trig_o so the very next
        // cycle already sees a non-zero count.
        if (trig_d)
            hold_d = holdoff_i;
        else
            hold_d = hold_free ? '0 : hold_q - HOLD_W'(1);

        sw_pend_d  = (sw_pend_q & ~g_sw) | sw_accept;
        per_pend_d = (per_pend_q & ~g_per) | (per_hit & ~per_pend_q);
        pps_pend_d = (pps_pend_q & ~g_pps) | pps_set;
        drop_d     = sw_drop | per_drop | pps_drop;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            go_q       <= 1'b0;
            sw_pend_q  <= 1'b0;
            per_pend_q <= 1'b0;
            pps_pend_q <= 1'b0;
            d_q        <= '0;
            n_q        <= '0;
            dly_q      <= '0;
            per_cnt_q  <= '0;
            pps_cnt_q  <= '0;
            pps_run_q  <= 1'b0;
            hold_q     <= '0;
            trig_q     <= 1'b0;
            src_q      <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            go_q       <= sw_ctrl_i[0];
            sw_pend_q  <= sw_pend_d;
            per_pend_q <= per_pend_d;
            pps_pend_q <= pps_pend_d;
            d_q        <= d_d;
            n_q        <= n_d;
            dly_q      <= dly_d;
            per_cnt_q  <= per_cnt_d;
            pps_cnt_q  <= pps_cnt_d;
            pps_run_q  <= pps_run_d;
            hold_q     <= hold_d;
            trig_q     <= trig_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign trig_o     = trig_q;
    assign trig_src_o = src_q;
    assign busy_o     = busy_q;
    assign sw_done_o  = done_q;
    assign dropped_o  = drop_q;

endmodule
